count_checker: RTL and testbench

Sequence checker that sits directly downstream of the 4-bit wrapping counter and consumes its four state bits every cycle. It confirms that the value advances by exactly +1 (mod 16) per cycle and locks onto a valid sequence. While locked it counts wrap-arounds and flags any discontinuity. It serves as the self-checking consumer for counter designs in compile and simulation flows.

---
 rtl/count_checker.sv | 129 ++++++++++++
 tb/tb_count_checker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// count_checker: sequence checker for a 4-bit wrapping counter.
// Confirms the sampled value advances by +1 (mod 16) every cycle, locks
// onto a valid run, then counts wrap-arounds and reports discontinuities.
// All outputs are driven from registers only.
module count_checker #(
  parameter int LOCK_COUNT = 2  // good steps needed to lock, 1..15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_state_0,
  input  logic i_state_1,
  input  logic i_state_2,
  input  logic i_state_3,
  output logic o_locked,
  output logic o_wrap,
  output logic o_error,
  output logic o_fault,
  output logic o_wraps_0,
  output logic o_wraps_1,
  output logic o_wraps_2,
  output logic o_wraps_3,
  output logic o_errors_0,
  output logic o_errors_1,
  output logic o_errors_2,
  output logic o_errors_3
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  logic [1:0] state_q;
  logic [3:0] prev_q;
  logic [3:0] run_q;
  logic [3:0] wraps_q;
  logic [3:0] errors_q;
  logic       fault_q;
  logic       wrap_q;
  logic       error_q;

  logic [3:0] s;
  logic [3:0] exp_val;
  logic [3:0] run_next;
  logic       step_ok;

  // Reassemble the counter value and work out the expected successor.
  always_comb begin
    s        = {i_state_3, i_state_2, i_state_1, i_state_0};
    exp_val  = prev_q + 4'd1;
    run_next = run_q + 4'd1;
    step_ok  = (s == exp_val);
  end

  // Sequence FSM with its event counters; pulses last exactly one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_SEARCH;
      prev_q   <= 4'd0;
      run_q    <= 4'd0;
      wraps_q  <= 4'd0;
      errors_q <= 4'd0;
      fault_q  <= 1'b0;
      wrap_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      prev_q  <= s;
      wrap_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          // First sample after reset: nothing to compare against yet.
          run_q   <= 4'd0;
          state_q <= ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (step_ok) begin
            if (run_next == LOCK_TARGET) begin
              run_q   <= 4'd0;
              state_q <= ST_LOCKED;
            end else begin
              run_q <= run_next;
            end
          end else begin
            run_q <= 4'd0;
          end
        end
        ST_LOCKED: begin
          if (step_ok) begin
            if (prev_q == 4'd15) begin
              wrap_q  <= 1'b1;
              wraps_q <= wraps_q + 4'd1;
            end
          end else begin
            error_q <= 1'b1;
            fault_q <= 1'b1;
            run_q   <= 4'd0;
            state_q <= ST_ACQUIRE;
            if (errors_q != 4'd15) begin
              errors_q <= errors_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= ST_SEARCH;
          run_q   <= 4'd0;
        end
      endcase
    end
  end

  // Output mapping straight from registers.
  always_comb begin
    o_locked   = (state_q == ST_LOCKED);
    o_wrap     = wrap_q;
    o_error    = error_q;
    o_fault    = fault_q;
    o_wraps_0  = wraps_q[0];
    o_wraps_1  = wraps_q[1];
    o_wraps_2  = wraps_q[2];
    o_wraps_3  = wraps_q[3];
    o_errors_0 = errors_q[0];
    o_errors_1 = errors_q[1];
    o_errors_2 = errors_q[2];
    o_errors_3 = errors_q[3];
  end

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed and randomized scenarios for count_checker,
// checked against a streak-based behavioural model of the sequence rules.
module tb_count_checker;

  localparam int LC = 2;

  logic clk;
  logic i_rst;
  logic i_state_0, i_state_1, i_state_2, i_state_3;
  logic o_locked, o_wrap, o_error, o_fault;
  logic o_wraps_0, o_wraps_1, o_wraps_2, o_wraps_3;
  logic o_errors_0, o_errors_1, o_errors_2, o_errors_3;

  int n_checks;
  int n_pass;

  // Model state: the lock condition is "LC or more consecutive good steps
  // since the first sample", which is all the FSM really implements.
  bit m_have;
  int m_prev;
  int m_streak;
  int m_wraps;
  int m_errors;
  bit m_fault;
  bit m_wrap_p;
  bit m_err_p;

  logic [11:0] exp_q[$];

  count_checker #(.LOCK_COUNT(LC)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_state_0(i_state_0), .i_state_1(i_state_1),
    .i_state_2(i_state_2), .i_state_3(i_state_3),
    .o_locked(o_locked), .o_wrap(o_wrap), .o_error(o_error), .o_fault(o_fault),
    .o_wraps_0(o_wraps_0), .o_wraps_1(o_wraps_1),
    .o_wraps_2(o_wraps_2), .o_wraps_3(o_wraps_3),
    .o_errors_0(o_errors_0), .o_errors_1(o_errors_1),
    .o_errors_2(o_errors_2), .o_errors_3(o_errors_3)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {o_locked, o_wrap, o_error, o_fault,
            o_wraps_3, o_wraps_2, o_wraps_1, o_wraps_0,
            o_errors_3, o_errors_2, o_errors_1, o_errors_0};
  endfunction

  function automatic logic [3:0] obs_wraps();
    return {o_wraps_3, o_wraps_2, o_wraps_1, o_wraps_0};
  endfunction

  function automatic logic [3:0] obs_errors();
    return {o_errors_3, o_errors_2, o_errors_1, o_errors_0};
  endfunction

  function automatic logic [11:0] model_vec();
    logic lk;
    lk = m_have && (m_streak >= LC);
    return {lk, m_wrap_p, m_err_p, m_fault, 4'(m_wraps), 4'(m_errors)};
  endfunction

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_streak = 0;
    m_wraps = 0; m_errors = 0; m_fault = 0;
    m_wrap_p = 0; m_err_p = 0;
  endtask

  task automatic model_step(input int v);
    bit was_locked;
    bit good;
    was_locked = m_have && (m_streak >= LC);
    m_wrap_p = 0;
    m_err_p  = 0;
    if (!m_have) begin
      m_have   = 1;
      m_streak = 0;
    end else begin
      good = (v == (m_prev + 1) % 16);
      if (was_locked && good && v == 0) begin
        m_wrap_p = 1;
        m_wraps  = (m_wraps + 1) % 16;
      end
      if (was_locked && !good) begin
        m_err_p  = 1;
        m_fault  = 1;
        m_errors = (m_errors < 15) ? m_errors + 1 : 15;
      end
      m_streak = good ? m_streak + 1 : 0;
    end
    m_prev = v;
  endtask

  // Driver tasks
  task automatic tick(input int v);
    logic [3:0] b;
    b = 4'(v);
    @(negedge clk);
    {i_state_3, i_state_2, i_state_1, i_state_0} = b;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    {i_state_3, i_state_2, i_state_1, i_state_0} = 4'd0;
    #1;
    n_checks++;
    if (obs() !== 12'd0) $display("FAIL reset_state: got %h want 000", obs());
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== 12'd0) $display("FAIL reset_held: got %h want 000", obs());
    else n_pass++;
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  // Free-running counter from reset; also leaves the DUT locked at 7.
  task automatic test_free_run();
    int wrap_pulses;
    wrap_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick(i % 16);
      if (o_wrap === 1'b1) wrap_pulses++;
      n_checks++;
      if (obs() !== model_vec())
        $display("FAIL free_run cyc %0d: got %h want %h", i, obs(), model_vec());
      else n_pass++;
      if (i == 1 || i == 2) begin
        n_checks++;
        if (o_locked !== (i == 2)) $display("FAIL lock_latency edge %0d: got %b", i + 1, o_locked);
        else n_pass++;
      end
    end
    n_checks++;
    if (wrap_pulses != 2) $display("FAIL free_run_wrap_pulses: got %0d want 2", wrap_pulses);
    else n_pass++;
    n_checks++;
    if (obs_wraps() !== 4'd2 || o_fault !== 1'b0 || obs_errors() !== 4'd0)
      $display("FAIL free_run_end: wraps %0d fault %b errors %0d want 2 0 0",
               obs_wraps(), o_fault, obs_errors());
    else n_pass++;
  endtask

  // Locked at 7: skip to 9, then 10, 11 re-lock.
  task automatic test_glitch();
    tick(9);
    n_checks++;
    if ({o_error, o_fault, o_locked, obs_errors()} !== {3'b110, 4'd1})
      $display("FAIL glitch_edge: err %b fault %b lock %b errors %0d want 1 1 0 1",
               o_error, o_fault, o_locked, obs_errors());
    else n_pass++;
    tick(10);
    n_checks++;
    if ({o_error, o_fault, o_locked} !== 3'b010)
      $display("FAIL glitch_10: err %b fault %b lock %b want 0 1 0", o_error, o_fault, o_locked);
    else n_pass++;
    tick(11);
    n_checks++;
    if ({o_error, o_fault, o_locked, obs_errors()} !== {3'b011, 4'd1})
      $display("FAIL glitch_relock: err %b fault %b lock %b errors %0d want 0 1 1 1",
               o_error, o_fault, o_locked, obs_errors());
    else n_pass++;
  endtask

  task automatic test_hold();
    int err_pulses;
    do_reset();
    for (int v = 0; v <= 5; v++) tick(v);
    err_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(5);
      if (o_error === 1'b1) err_pulses++;
      n_checks++;
      if (obs() !== model_vec())
        $display("FAIL hold cyc %0d: got %h want %h", i, obs(), model_vec());
      else n_pass++;
    end
    n_checks++;
    if (err_pulses != 1 || obs_errors() !== 4'd1 || o_locked !== 1'b0)
      $display("FAIL hold_end: pulses %0d errors %0d lock %b want 1 1 0",
               err_pulses, obs_errors(), o_locked);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int cur;
    do_reset();
    for (cur = 0; cur <= 3; cur++) tick(cur);
    cur = 3;
    for (int g = 0; g < 20; g++) begin
      cur = (cur + 2) % 16;
      tick(cur);
      n_checks++;
      if (o_error !== 1'b1 || obs() !== model_vec())
        $display("FAIL saturate glitch %0d: got %h want %h", g, obs(), model_vec());
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
        cur = (cur + 1) % 16;
        tick(cur);
      end
    end
    n_checks++;
    if (obs_errors() !== 4'd15 || o_locked !== 1'b1)
      $display("FAIL saturate_end: errors %0d lock %b want 15 1", obs_errors(), o_locked);
    else n_pass++;
  endtask

  task automatic test_wrap_count();
    do_reset();
    for (int i = 0; i <= 17 * 16; i++) tick(i % 16);
    n_checks++;
    if (obs_wraps() !== 4'd1 || obs() !== model_vec())
      $display("FAIL wrap_count: wraps %0d want 1 (vec %h want %h)",
               obs_wraps(), obs(), model_vec());
    else n_pass++;
  endtask

  task automatic test_reset_midwrap();
    do_reset();
    for (int i = 0; i <= 48; i++) tick(i % 16);
    n_checks++;
    if (o_wrap !== 1'b1 || obs_wraps() !== 4'd3)
      $display("FAIL midwrap_pre: wrap %b wraps %0d want 1 3", o_wrap, obs_wraps());
    else n_pass++;
    #2;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 12'd0) $display("FAIL midwrap_async_clear: got %h want 000", obs());
    else n_pass++;
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(i);
      n_checks++;
      if (o_locked !== (i == 2)) $display("FAIL midwrap_relock edge %0d: got %b", i + 1, o_locked);
      else n_pass++;
    end
  endtask

  // Randomized: mostly good steps, occasional holds and jumps.
  task automatic test_random();
    int cur;
    logic [11:0] e;
    do_reset();
    cur = int'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: cur = cur;
        1: cur = int'($urandom_range(0, 15));
        default: cur = (cur + 1) % 16;
      endcase
      tick(cur);
      exp_q.push_back(model_vec());
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) $display("FAIL random cyc %0d: got %h want %h", i, obs(), e);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    test_reset();
    test_free_run();
    test_glitch();
    test_hold();
    test_saturate();
    test_wrap_count();
    test_reset_midwrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
